// File: rtl/ddc_edid_pkg.sv
// ddc_edid_pkg: shared sequencer state type and EDID layout constants
package ddc_edid_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_BLK_CHK,
    S_RETRY,
    S_HPD_LOW,
    S_RUN
  } state_t;
  localparam logic [6:0] EDID_DEV_ADDR  = 7'h50;
  localparam logic [7:0] EDID_BLK_BYTES = 8'd128;
  localparam logic [7:0] EDID_EXT_OFS   = 8'd126;
  localparam logic [7:0] EDID_CSUM_OFS  = 8'd127;
endpackage

// File: rtl/ddc_hpd_debounce.sv
// ddc_hpd_debounce: 2-FF synchroniser plus stability counter for the raw sink HPD
// Ports: clk, rst_n (sync active-low); hpd_raw async input; hpd_deb accepted level.
module ddc_hpd_debounce #(
  parameter int P_DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hpd_raw,
  output logic hpd_deb
);
  localparam int CW = $clog2(P_DEB_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  // cnt counts consecutive clocks where the synced level differs from the accepted one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      hpd_deb <= 1'b0;
    end else begin
      sync <= {sync[0], hpd_raw};
      if (sync[1] == hpd_deb) cnt <= '0;
      else if (cnt == CW'(P_DEB_CYCLES - 1)) begin
        cnt     <= '0;
        hpd_deb <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ddc_edid_hpd_sequencer.sv
// ddc_edid_hpd_sequencer: copies the sink EDID into RAM with checksum/retry, then pulses source HPDs
// Ports: i_local_clk, i_rst_n (sync active-low); i_ddc3_hpd raw sink HPD;
//  o_rd_req/o_rd_dev/o_rd_addr/i_rd_ack/i_rd_data/i_rd_err byte-read handshake to the I2C master;
//  o_ram_we/o_ram_addr/o_ram_wdata EDID RAM write port; o_ddc1_hpd/o_ddc2_hpd source HPDs;
//  o_edid_valid verified EDID present, o_busy read in progress, o_err all attempts failed (sticky).
module ddc_edid_hpd_sequencer
  import ddc_edid_pkg::*;
#(
  parameter int P_DEB_CYCLES     = 500_000,
  parameter int P_HPD_LOW_CYCLES = 5_000_000,
  parameter int P_MAX_BLOCKS     = 2,
  parameter int P_RETRY          = 3
) (
  input  logic       i_local_clk,
  input  logic       i_rst_n,
  input  logic       i_ddc3_hpd,
  output logic       o_rd_req,
  output logic [6:0] o_rd_dev,
  output logic [7:0] o_rd_addr,
  input  logic       i_rd_ack,
  input  logic [7:0] i_rd_data,
  input  logic       i_rd_err,
  output logic       o_ram_we,
  output logic [7:0] o_ram_addr,
  output logic [7:0] o_ram_wdata,
  output logic       o_ddc1_hpd,
  output logic       o_ddc2_hpd,
  output logic       o_edid_valid,
  output logic       o_busy,
  output logic       o_err
);
  localparam int HW = $clog2(P_HPD_LOW_CYCLES + 1);
  localparam int TW = $clog2(P_RETRY + 2);
  state_t        state;
  logic          hpd_deb, hpd_deb_q, rise, fall, more_blk, hpd;
  logic [7:0]    addr, sum, ext;
  logic [TW-1:0] tries;
  logic [HW-1:0] low_cnt;
  ddc_hpd_debounce #(.P_DEB_CYCLES(P_DEB_CYCLES)) u_deb (
    .clk    (i_local_clk),
    .rst_n  (i_rst_n),
    .hpd_raw(i_ddc3_hpd),
    .hpd_deb(hpd_deb)
  );
  assign rise       = hpd_deb & ~hpd_deb_q;
  assign fall       = ~hpd_deb & hpd_deb_q;
  // a second block is read only from block 0 when the sink advertises an extension
  assign more_blk   = (P_MAX_BLOCKS > 1) && !addr[7] && (ext != 8'd0);
  assign o_rd_dev   = EDID_DEV_ADDR;
  assign o_rd_addr  = addr;
  assign o_ddc1_hpd = hpd;
  assign o_ddc2_hpd = hpd;
  assign o_busy     = state inside {S_RD_REQ, S_RD_WAIT, S_BLK_CHK};
  always_ff @(posedge i_local_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      hpd_deb_q    <= 1'b0;
      addr         <= '0;
      sum          <= '0;
      ext          <= '0;
      tries        <= '0;
      low_cnt      <= '0;
      o_rd_req     <= 1'b0;
      o_ram_we     <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_wdata  <= '0;
      hpd          <= 1'b0;
      o_edid_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      hpd_deb_q <= hpd_deb;
      o_ram_we  <= 1'b0;
      // sink unplug overrides everything; any in-flight ack is dropped by leaving RD_WAIT
      if (fall) begin
        state        <= S_IDLE;
        o_rd_req     <= 1'b0;
        hpd          <= 1'b0;
        o_edid_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (rise) begin
            state        <= S_RD_REQ;
            o_err        <= 1'b0;
            o_edid_valid <= 1'b0;
            addr         <= '0;
            sum          <= '0;
            tries        <= '0;
          end
          S_RD_REQ: begin
            o_rd_req <= 1'b1;
            state    <= S_RD_WAIT;
          end
          S_RD_WAIT: if (i_rd_err) begin
            o_rd_req <= 1'b0;
            state    <= S_RETRY;
          end else if (i_rd_ack) begin
            o_rd_req    <= 1'b0;
            o_ram_we    <= 1'b1;
            o_ram_addr  <= addr;
            o_ram_wdata <= i_rd_data;
            sum         <= sum + i_rd_data;
            if (addr == EDID_EXT_OFS) ext <= i_rd_data;
            if (addr[6:0] == EDID_CSUM_OFS[6:0]) state <= S_BLK_CHK;
            else begin
              addr  <= addr + 8'd1;
              state <= S_RD_REQ;
            end
          end
          S_BLK_CHK: if (sum != 8'd0) state <= S_RETRY;
          else if (more_blk) begin
            sum   <= '0;
            addr  <= EDID_BLK_BYTES;
            state <= S_RD_REQ;
          end else begin
            o_edid_valid <= 1'b1;
            low_cnt      <= '0;
            state        <= S_HPD_LOW;
          end
          S_RETRY: if (tries < TW'(P_RETRY)) begin
            tries        <= tries + 1'b1;
            addr         <= '0;
            sum          <= '0;
            o_edid_valid <= 1'b0;
            state        <= S_RD_REQ;
          end else begin
            o_err   <= 1'b1;
            low_cnt <= '0;
            state   <= S_HPD_LOW;
          end
          S_HPD_LOW: if (low_cnt == HW'(P_HPD_LOW_CYCLES - 1)) begin
            hpd   <= 1'b1;
            state <= S_RUN;
          end else low_cnt <= low_cnt + 1'b1;
          S_RUN: hpd <= 1'b1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ddc_edid_hpd_sequencer.sv
// tb_ddc_edid_hpd_sequencer: randomized EDID sink responder with a queue scoreboard of expected RAM writes
module tb_ddc_edid_hpd_sequencer;
  localparam int P_DEB = 16;
  localparam int P_LOW = 64;
  localparam int P_RTY = 2;
  logic       clk = 1'b0;
  logic       i_rst_n, i_ddc3_hpd, i_rd_ack, i_rd_err;
  logic [7:0] i_rd_data;
  logic       o_rd_req, o_ram_we, o_ddc1_hpd, o_ddc2_hpd, o_edid_valid, o_busy, o_err;
  logic [6:0] o_rd_dev;
  logic [7:0] o_rd_addr, o_ram_addr, o_ram_wdata;
  int n_pass = 0, n_total = 0;
  logic [7:0]  edid [256];
  logic [15:0] exp_q [$];
  bit exp_valid, exp_err, both = 0, late_done = 0;
  int err_at = -1, hang_at = -1, attempt = 0;

  always #5 clk = ~clk;

  ddc_edid_hpd_sequencer #(
    .P_DEB_CYCLES(P_DEB), .P_HPD_LOW_CYCLES(P_LOW), .P_MAX_BLOCKS(2), .P_RETRY(P_RTY)
  ) dut (
    .i_local_clk(clk), .i_rst_n(i_rst_n), .i_ddc3_hpd(i_ddc3_hpd),
    .o_rd_req(o_rd_req), .o_rd_dev(o_rd_dev), .o_rd_addr(o_rd_addr),
    .i_rd_ack(i_rd_ack), .i_rd_data(i_rd_data), .i_rd_err(i_rd_err),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .o_ddc1_hpd(o_ddc1_hpd), .o_ddc2_hpd(o_ddc2_hpd),
    .o_edid_valid(o_edid_valid), .o_busy(o_busy), .o_err(o_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic gen_edid(input logic [7:0] ext, input bit bad);
    int s0 = 0, s1 = 0;
    for (int i = 0; i < 256; i++) edid[i] = 8'($urandom);
    edid[126] = ext;
    for (int i = 0; i < 127; i++) s0 += edid[i];
    for (int i = 128; i < 255; i++) s1 += edid[i];
    edid[127] = 8'(256 - (s0 % 256));
    edid[255] = 8'(256 - (s1 % 256));
    if (bad) edid[127] = edid[127] + 8'd1;
  endtask

  // Reference: each attempt reads min(ext+1,2) blocks in order; an injected error ends attempt 0,
  // a block whose bytes do not sum to 0 mod 256 ends the attempt; 1+P_RTY attempts in total.
  task automatic model();
    exp_valid = 0;
    for (int t = 0; t <= P_RTY && !exp_valid; t++) begin
      int nblk = (edid[126] == 8'd0) ? 1 : 2;
      bit ok = 1;
      for (int b = 0; b < nblk && ok; b++) begin
        int s = 0;
        for (int i = 0; i < 128 && ok; i++) begin
          int a = b * 128 + i;
          if (t == 0 && a == err_at) ok = 0;
          else begin
            exp_q.push_back({8'(a), edid[a]});
            s += edid[a];
          end
        end
        if (ok && (s % 256) != 0) ok = 0;
      end
      exp_valid = ok;
    end
    exp_err = !exp_valid;
  endtask

  // I2C master stand-in: answers each request after 0..3 idle clocks
  initial begin
    int a;
    i_rd_ack = 0; i_rd_err = 0; i_rd_data = 0;
    forever begin
      @(negedge clk);
      if (o_rd_req) begin
        a = int'(o_rd_addr);
        if (a == 0) attempt++;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (a == hang_at) begin
          while (o_rd_req) @(negedge clk);
          repeat (3) @(negedge clk);
          i_rd_ack = 1; i_rd_data = 8'hA5;
          @(negedge clk);
          i_rd_ack = 0; late_done = 1;
        end else begin
          i_rd_data = edid[a];
          i_rd_err  = (attempt == 1 && a == err_at);
          i_rd_ack  = !i_rd_err || both;
          @(negedge clk);
          i_rd_ack = 0; i_rd_err = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_ram_we) begin
      if (exp_q.size() == 0) check("ram write while none expected", 32'(o_ram_we), 0);
      else check("ram write addr/data", {o_ram_addr, o_ram_wdata}, exp_q.pop_front());
    end
  end

  task automatic reset_chk(input string nm);
    i_ddc3_hpd = 0; i_rst_n = 0;
    @(negedge clk);
    check({nm, " outputs zero"}, {o_rd_req, o_ram_we, o_ram_addr, o_ram_wdata, o_ddc1_hpd,
          o_ddc2_hpd, o_edid_valid, o_busy, o_err}, 0);
    exp_q.delete();
    i_rst_n = 1;
  endtask

  task automatic read_run(input string nm, input logic [7:0] ext, input bit bad, input int e_at,
                          input bit e_both);
    int k = 0;
    gen_edid(ext, bad);
    err_at = e_at; both = e_both; attempt = 0;
    model();
    i_ddc3_hpd = 1;
    while (!o_busy && k < 200) begin @(negedge clk); k++; end
    check({nm, " read started"}, 32'(o_busy), 1);
    k = 0;
    while (!(o_edid_valid || o_err) && k < 20000) begin @(negedge clk); k++; end
    check({nm, " edid_valid"}, 32'(o_edid_valid), 32'(exp_valid));
    check({nm, " err"}, 32'(o_err), 32'(exp_err));
    check({nm, " hpd low at entry"}, {o_ddc1_hpd, o_ddc2_hpd}, 0);
    k = 0;
    while (!o_ddc1_hpd && k < 200) begin @(negedge clk); k++; end
    check({nm, " hpd low cycles"}, k, P_LOW);
    check({nm, " ddc2 follows ddc1"}, 32'(o_ddc2_hpd), 1);
    check({nm, " pending writes"}, exp_q.size(), 0);
    err_at = -1; both = 0;
  endtask

  task automatic drop_hpd(input string nm, input bit err_exp);
    int k = 0;
    i_ddc3_hpd = 0;
    do begin @(negedge clk); k++; end while (o_ddc1_hpd && k < 100);
    check({nm, " unplug latency"}, k, P_DEB + 3);
    check({nm, " after unplug hpd/valid/busy"}, {o_ddc2_hpd, o_edid_valid, o_busy}, 0);
    check({nm, " err retained"}, 32'(o_err), 32'(err_exp));
  endtask

  initial begin
    int k;
    bit saw;
    i_rst_n = 0; i_ddc3_hpd = 0;
    repeat (3) @(negedge clk);
    reset_chk("reset");
    repeat (3) @(negedge clk);
    read_run("ext0", 8'd0, 0, -1, 0);
    drop_hpd("ext0", 0);
    read_run("ext1", 8'd1, 0, -1, 0);
    drop_hpd("ext1", 0);
    read_run("ext3", 8'd3, 0, -1, 0);
    drop_hpd("ext3", 0);
    read_run("badsum", 8'd0, 1, -1, 0);
    drop_hpd("badsum", 1);
    read_run("err40", 8'(($urandom & 1)), 0, 40, 0);
    drop_hpd("err40", 0);
    read_run("ackerr", 8'd0, 0, 10, 1);
    drop_hpd("ackerr", 0);
    // glitch shorter than the debounce window
    i_ddc3_hpd = 1; saw = 0;
    repeat (10) begin @(negedge clk); saw |= o_rd_req; end
    i_ddc3_hpd = 0;
    repeat (40) begin @(negedge clk); saw |= o_rd_req; end
    check("glitch no request", 32'(saw), 0);
    // unplug while byte 60 is outstanding, then a late ack
    gen_edid(8'd0, 0);
    for (int i = 0; i < 60; i++) exp_q.push_back({8'(i), edid[i]});
    hang_at = 60; attempt = 0; late_done = 0; k = 0;
    i_ddc3_hpd = 1;
    while (!(o_rd_req && o_rd_addr == 8'd60) && k < 5000) begin @(negedge clk); k++; end
    check("unplug: request at 60", {o_rd_req, o_rd_addr}, {1'b1, 8'd60});
    check("rd_dev", 32'(o_rd_dev), 32'h50);
    i_ddc3_hpd = 0; k = 0;
    while (o_rd_req && k < 40) begin @(negedge clk); k++; end
    check("unplug: request dropped", 32'(o_rd_req), 0);
    repeat (12) @(negedge clk);
    check("unplug: late ack delivered", 32'(late_done), 1);
    check("unplug: idle outputs", {o_rd_req, o_busy, o_ddc1_hpd, o_ddc2_hpd, o_edid_valid}, 0);
    check("unplug: pending writes", exp_q.size(), 0);
    hang_at = -1;
    // reset while in RUN
    read_run("pre_rst", 8'd0, 0, -1, 0);
    reset_chk("reset in RUN");
    repeat (5) @(negedge clk);
    // reset with a request outstanding
    gen_edid(8'd0, 0);
    for (int i = 0; i < 20; i++) exp_q.push_back({8'(i), edid[i]});
    hang_at = 20; attempt = 0; late_done = 0; k = 0;
    i_ddc3_hpd = 1;
    while (!(o_rd_req && o_rd_addr == 8'd20) && k < 5000) begin @(negedge clk); k++; end
    check("wait reset: request at 20", {o_rd_req, o_rd_addr}, {1'b1, 8'd20});
    check("wait reset: writes before reset", exp_q.size(), 0);
    reset_chk("reset in RD_WAIT");
    repeat (10) @(negedge clk);
    check("wait reset: late ack ignored", {late_done, o_busy, o_rd_req}, {1'b1, 1'b0, 1'b0});
    hang_at = -1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
